// File: rtl/banner_msg_buffer.sv
// banner_msg_buffer: writable message store and 4-digit scroll window for the
// 7-segment banner. Characters arrive over a valid/ready stream; the scroll
// position advances on the banner tick.
// Optional macro BANNER_WRAP_EN: circular scrolling. When it is undefined
// (default build), scrolling is clamped so the window never runs past the end.
module banner_msg_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          wr_valid,
  input  logic [3:0]    wr_data,
  input  logic          wr_last,
  output logic          wr_ready,
  input  logic          tick,
  input  logic          en,
  input  logic          dir,
  output logic [15:0]   window,
  output logic [3:0]    blank,
  output logic [PW:0]   len,
  output logic          loading
);

  localparam int unsigned LW      = PW + 1;
  localparam int unsigned LEN_RST = (DEPTH < 10) ? DEPTH : 10;

  typedef enum logic {
    S_SHOW = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_mem [DEPTH];
  logic [PW-1:0] r_pos;
  logic [LW-1:0] r_wr_ptr;
  logic [LW-1:0] r_len;
  logic [PW-1:0] w_pos_nxt;
  logic [LW-1:0] w_idx [4];
  logic [3:0]    w_blank;
  logic          w_wr_fire;

  assign len       = r_len;
  assign w_wr_fire = wr_valid && wr_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_SHOW;
    else       r_state <= w_state_nxt;
  end

  // Next state: load_start enters/restarts LOAD, an accepted last write leaves it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SHOW: if (load_start) w_state_nxt = S_LOAD;
      S_LOAD: if (!load_start && w_wr_fire && wr_last) w_state_nxt = S_SHOW;
      default: w_state_nxt = S_SHOW;
    endcase
  end

  // Message memory, write pointer, length and scroll position
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= (i < int'(LEN_RST)) ? 4'(i) : 4'd0;
      end
      r_pos    <= '0;
      r_wr_ptr <= '0;
      r_len    <= LW'(LEN_RST);
    end else begin
      case (r_state)
        S_SHOW: begin
          if (load_start) begin
            r_wr_ptr <= '0;
            r_pos    <= '0;
          end else if (tick && en) begin
            r_pos <= w_pos_nxt;
          end
        end
        S_LOAD: begin
          if (load_start) begin
            r_wr_ptr <= '0;
          end else if (w_wr_fire) begin
            // Once the pointer reaches DEPTH further characters are dropped
            if (r_wr_ptr != LW'(DEPTH)) begin
              r_mem[r_wr_ptr[PW-1:0]] <= wr_data;
              r_wr_ptr                <= r_wr_ptr + LW'(1);
            end
            if (wr_last) begin
              r_len <= (r_wr_ptr == LW'(DEPTH)) ? r_wr_ptr : r_wr_ptr + LW'(1);
              r_pos <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BANNER_WRAP_EN
  // Circular scroll step: wraps between 0 and len-1
  always_comb begin
    w_pos_nxt = r_pos;
    if (dir) w_pos_nxt = (r_pos == '0) ? PW'(r_len - LW'(1)) : r_pos - PW'(1);
    else     w_pos_nxt = ({1'b0, r_pos} == r_len - LW'(1)) ? '0 : r_pos + PW'(1);
  end
`else
  logic [LW-1:0] w_max_pos;

  // Clamped scroll step: position held within 0..max(len-4, 0)
  always_comb begin
    w_max_pos = (r_len > LW'(4)) ? r_len - LW'(4) : '0;
    w_pos_nxt = r_pos;
    if (dir) w_pos_nxt = (r_pos == '0) ? '0 : r_pos - PW'(1);
    else     w_pos_nxt = ({1'b0, r_pos} >= w_max_pos) ? PW'(w_max_pos) : r_pos + PW'(1);
  end
`endif

  // Per-digit memory index and blanking; wrap needs only one subtract since pos < len
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_idx[k] = {1'b0, r_pos} + LW'(k);
`ifdef BANNER_WRAP_EN
      if (w_idx[k] >= r_len) w_idx[k] = w_idx[k] - r_len;
      w_blank[k] = (LW'(k) >= r_len);
`else
      w_blank[k] = (w_idx[k] >= r_len);
`endif
    end
  end

  // Outputs: LOAD shows a fully blanked display, SHOW presents the window
  always_comb begin
    wr_ready = 1'b0;
    loading  = 1'b0;
    window   = '0;
    blank    = 4'b1111;
    if (r_state == S_LOAD) begin
      wr_ready = 1'b1;
      loading  = 1'b1;
    end else begin
      blank = w_blank;
      for (int k = 0; k < 4; k++) begin
        window[4*k +: 4] = w_blank[k] ? 4'd0 : r_mem[w_idx[k][PW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_banner_msg_buffer.sv
// Bench for banner_msg_buffer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_banner_msg_buffer;

  localparam int DEPTH = 16;
  localparam int PW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic          wr_valid;
  logic [3:0]    wr_data;
  logic          wr_last;
  logic          wr_ready;
  logic          tick;
  logic          en;
  logic          dir;
  logic [15:0]   window;
  logic [3:0]    blank;
  logic [PW:0]   len;
  logic          loading;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model state: plain integers, unbounded write count
  int m_mem [DEPTH];
  int m_len;
  int m_pos;
  int m_cnt;
  bit m_loading;

  banner_msg_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .wr_ready   (wr_ready),
    .tick       (tick),
    .en         (en),
    .dir        (dir),
    .window     (window),
    .blank      (blank),
    .len        (len),
    .loading    (loading)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = (i < 10) ? i : 0;
    m_len     = 10;
    m_pos     = 0;
    m_cnt     = 0;
    m_loading = 1'b0;
  endfunction

  function automatic int m_scroll(input int p, input bit d);
`ifdef BANNER_WRAP_EN
    return d ? (p + m_len - 1) % m_len : (p + 1) % m_len;
`else
    int maxp = (m_len > 4) ? m_len - 4 : 0;
    if (d) return (p > 0) ? p - 1 : 0;
    return (p < maxp) ? p + 1 : maxp;
`endif
  endfunction

  function automatic int exp_blank();
    int b = 0;
    if (m_loading) return 15;
    for (int k = 0; k < 4; k++) begin
`ifdef BANNER_WRAP_EN
      if (k >= m_len) b |= (1 << k);
`else
      if (m_pos + k >= m_len) b |= (1 << k);
`endif
    end
    return b;
  endfunction

  function automatic int exp_window();
    int w = 0;
    int b = exp_blank();
    int idx;
    if (m_loading) return 0;
    for (int k = 0; k < 4; k++) begin
      if (((b >> k) & 1) == 0) begin
`ifdef BANNER_WRAP_EN
        idx = (m_pos + k) % m_len;
`else
        idx = m_pos + k;
`endif
        w |= m_mem[idx] << (4 * k);
      end
    end
    return w;
  endfunction

  // Model update from the message-buffer rules
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_reset();
    end else if (!m_loading) begin
      if (load_start) begin
        m_loading = 1'b1;
        m_cnt     = 0;
        m_pos     = 0;
      end else if (tick && en) begin
        m_pos = m_scroll(m_pos, dir);
      end
    end else begin
      if (load_start) begin
        m_cnt = 0;
      end else if (wr_valid) begin
        if (m_cnt < DEPTH) m_mem[m_cnt] = int'(wr_data);
        m_cnt++;
        if (wr_last) begin
          m_len     = (m_cnt < DEPTH) ? m_cnt : DEPTH;
          m_pos     = 0;
          m_loading = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_window",   int'(window),   exp_window());
      chk("cyc_blank",    int'(blank),    exp_blank());
      chk("cyc_len",      int'(len),      m_len);
      chk("cyc_wr_ready", int'(wr_ready), int'(m_loading));
      chk("cyc_loading",  int'(loading),  int'(m_loading));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input int w, input int b, input int l, input int ld);
    chk({name, "_window"},  int'(window),   w);
    chk({name, "_blank"},   int'(blank),    b);
    chk({name, "_len"},     int'(len),      l);
    chk({name, "_wr_ready"}, int'(wr_ready), ld);
    chk({name, "_loading"}, int'(loading),  ld);
  endtask

  task automatic do_tick(input bit d, input bit e);
    tick = 1'b1; en = e; dir = d;
    cyc();
    tick = 1'b0; en = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic start_load();
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
  endtask

  task automatic write(input logic [3:0] d, input bit last, input bit gap);
    if (gap) begin
      wr_valid = 1'b0;
      cyc();
    end
    wr_valid = 1'b1; wr_data = d; wr_last = last;
    cyc();
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  int last_div;

  initial begin
    reset = 1'b1; load_start = 1'b0; wr_valid = 1'b0; wr_data = 4'd0;
    wr_last = 1'b0; tick = 1'b0; en = 1'b0; dir = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    pin("reset", 'h3210, 0, 10, 0);

    // Forward scrolling and the enable gate
    for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b1);
    pin("fwd3", 'h6543, 0, 10, 0);
    do_tick(1'b0, 1'b0);
    pin("en_off", 'h6543, 0, 10, 0);

    do_reset();
`ifdef BANNER_WRAP_EN
    for (int i = 0; i < 9; i++) do_tick(1'b0, 1'b1);
    pin("wrap_fwd9", 'h2109, 0, 10, 0);
    do_tick(1'b0, 1'b1);
    pin("wrap_fwd10", 'h3210, 0, 10, 0);
    do_tick(1'b1, 1'b1);
    pin("wrap_back", 'h2109, 0, 10, 0);
`else
    for (int i = 0; i < 10; i++) do_tick(1'b0, 1'b1);
    pin("clamp_fwd10", 'h9876, 0, 10, 0);
    for (int i = 0; i < 10; i++) do_tick(1'b1, 1'b1);
    pin("clamp_back10", 'h3210, 0, 10, 0);
`endif

    // Short message with gapped writes
    start_load();
    pin("in_load", 0, 'hF, 10, 1);
    write(4'hA, 1'b0, 1'b1);
    write(4'hB, 1'b0, 1'b1);
    write(4'hC, 1'b1, 1'b1);
    pin("abc", 'h0CBA, 'h8, 3, 0);
`ifdef BANNER_WRAP_EN
    do_tick(1'b1, 1'b1);
    do_tick(1'b1, 1'b1);
    pin("abc_back2", 'h0ACB, 'h8, 3, 0);
`else
    do_tick(1'b1, 1'b1);
    do_tick(1'b0, 1'b1);
    pin("abc_clamped", 'h0CBA, 'h8, 3, 0);
`endif

    // load_start during LOAD wins over a same-cycle write
    start_load();
    write(4'h7, 1'b0, 1'b0);
    load_start = 1'b1; wr_valid = 1'b1; wr_data = 4'h9; wr_last = 1'b1;
    cyc();
    load_start = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
    pin("restart", 0, 'hF, 3, 1);
    write(4'h5, 1'b1, 1'b0);
    pin("restart_len1", 'h0005, 'hE, 1, 0);

    // Overflow: 20 characters, only the first DEPTH are kept
    start_load();
    for (int i = 0; i < 20; i++) write(4'(i % 16), (i == 19), 1'b0);
    pin("ovf", 'h3210, 0, 16, 0);
`ifdef BANNER_WRAP_EN
    do_tick(1'b1, 1'b1);
    pin("ovf_back", 'h210F, 0, 16, 0);
`else
    for (int i = 0; i < 14; i++) do_tick(1'b0, 1'b1);
    pin("ovf_top", 'hFEDC, 0, 16, 0);
`endif

    // Reset mid-load restores the defaults immediately
    start_load();
    write(4'h1, 1'b0, 1'b0);
    write(4'h2, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    pin("async_rst", 'h3210, 0, 10, 0);
    cyc();
    reset = 1'b0;
    cyc();
    pin("after_rst", 'h3210, 0, 10, 0);

    // Randomized traffic, message length bias varies per epoch
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) last_div = ((c / 500) % 2 == 0) ? 4 : 30;
      load_start = ($urandom_range(0, 39) == 0);
      wr_valid   = ($urandom_range(0, 1) == 1);
      wr_data    = 4'($urandom);
      wr_last    = ($urandom_range(0, last_div) == 0);
      tick       = ($urandom_range(0, 2) == 0);
      en         = ($urandom_range(0, 3) != 0);
      dir        = ($urandom_range(0, 1) == 1);
      reset      = ($urandom_range(0, 499) == 0);
      cyc();
    end

    reset = 1'b0; load_start = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; tick = 1'b0;
    repeat (3) cyc();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
